// File: rtl/coin_acceptor.sv
// Coin sensor front end: sync, debounce, reject, queue, and paced issue to the vending machine.
// Optional COIN_ACCEPTOR_STATS_EN adds saturating dollar/quarter issue counters.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 3
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       coin_dollar_raw,
  input  logic       coin_quarter_raw,
  output logic       D_in,
  output logic       Q_in,
  output logic       coin_reject,
  output logic       coin_drop,
`ifdef COIN_ACCEPTOR_STATS_EN
  output logic [7:0] dollar_count,
  output logic [7:0] quarter_count,
`endif
  output logic       fifo_full
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  // Bit 1 is the dollar line, bit 0 the quarter line.
  logic [1:0]         s1_q, s2_q;
  logic [1:0]         lvl_q, lvl_d, lvlp_q;
  logic [1:0]         arm_q, arm_d;
  logic [1:0]         warm_q;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         evt;
  logic               both, one;

  logic [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]           count_q, count_d;
  logic                  push, pop, full_now;

  state_t        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;

  logic d_in_q, d_in_d, q_in_q, q_in_d;
  logic rej_q, rej_d, drop_q, drop_d, full_q, full_d;

  // A line only arms after a genuine low sample has crossed the synchronizer.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    arm_d = arm_q | ({2{warm_q[1]}} & ~lvl_q & ~s2_q);
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) lvl_d[i] = ~lvl_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign evt      = lvl_q & ~lvlp_q & arm_q;
  assign both     = &evt;
  assign one      = ^evt;
  assign full_now = (count_q == FULL);
  assign push     = one & (~full_now | pop);

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = GAP;
        gap_d   = GW'(GAP_CYCLES);
      end
      GAP: begin
        if (gap_q == GW'(1)) state_d = IDLE;
        else gap_d = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) begin
      mem_d[wr_q] = evt[1];
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    d_in_d = pop & mem_q[rd_q];
    q_in_d = pop & ~mem_q[rd_q];
    rej_d  = both;
    drop_d = one & full_now & ~pop;
    full_d = (count_d == FULL);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      lvl_q   <= '0;
      lvlp_q  <= '0;
      arm_q   <= '0;
      warm_q  <= '0;
      cnt_q   <= '0;
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      state_q <= IDLE;
      gap_q   <= '0;
      d_in_q  <= 1'b0;
      q_in_q  <= 1'b0;
      rej_q   <= 1'b0;
      drop_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      s1_q    <= {coin_dollar_raw, coin_quarter_raw};
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      lvlp_q  <= lvl_q;
      arm_q   <= arm_d;
      warm_q  <= {warm_q[0], 1'b1};
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      state_q <= state_d;
      gap_q   <= gap_d;
      d_in_q  <= d_in_d;
      q_in_q  <= q_in_d;
      rej_q   <= rej_d;
      drop_q  <= drop_d;
      full_q  <= full_d;
    end
  end

  assign D_in        = d_in_q;
  assign Q_in        = q_in_q;
  assign coin_reject = rej_q;
  assign coin_drop   = drop_q;
  assign fifo_full   = full_q;

`ifdef COIN_ACCEPTOR_STATS_EN
  logic [7:0] dcnt_q, dcnt_d, qcnt_q, qcnt_d;

  always_comb begin
    dcnt_d = dcnt_q;
    qcnt_d = qcnt_q;
    if (d_in_d && dcnt_q != 8'hff) dcnt_d = dcnt_q + 8'd1;
    if (q_in_d && qcnt_q != 8'hff) qcnt_d = qcnt_q + 8'd1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q <= '0;
      qcnt_q <= '0;
    end else begin
      dcnt_q <= dcnt_d;
      qcnt_q <= qcnt_d;
    end
  end

  assign dollar_count  = dcnt_q;
  assign quarter_count = qcnt_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed + randomized bench for coin_acceptor against a queue-based reference model.
// Stats ports are exercised when COIN_ACCEPTOR_STATS_EN is defined.
module tb_coin_acceptor;

  localparam int DB    = 4;
  localparam int DEPTH = 4;
  localparam int GAP   = 3;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic coin_dollar_raw = 1'b0;
  logic coin_quarter_raw = 1'b0;
  logic D_in, Q_in, coin_reject, coin_drop, fifo_full;
`ifdef COIN_ACCEPTOR_STATS_EN
  logic [7:0] dollar_count, quarter_count;
`endif

  coin_acceptor #(
    .DEBOUNCE_CYCLES(DB),
    .FIFO_DEPTH(DEPTH),
    .GAP_CYCLES(GAP)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .coin_dollar_raw(coin_dollar_raw),
    .coin_quarter_raw(coin_quarter_raw),
    .D_in(D_in),
    .Q_in(Q_in),
    .coin_reject(coin_reject),
    .coin_drop(coin_drop),
`ifdef COIN_ACCEPTOR_STATS_EN
    .dollar_count(dollar_count),
    .quarter_count(quarter_count),
`endif
    .fifo_full(fifo_full)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;
  int tickno = 0;

  // Reference model: raw history, per-line run length, and a coin queue.
  int  h1[2], h2[2], run[2];
  bit  lvl[2], arm[2], rise[2];
  bit  fq[$];
  int  cool;
  bit  ex_D, ex_Q, ex_rej, ex_drop, ex_full;
  int  ex_dcnt, ex_qcnt;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      h1[i] = -1; h2[i] = -1; run[i] = 0;
      lvl[i] = 0; arm[i] = 0; rise[i] = 0;
    end
    fq.delete();
    cool = 0;
    ex_D = 0; ex_Q = 0; ex_rej = 0; ex_drop = 0; ex_full = 0;
    ex_dcnt = 0; ex_qcnt = 0;
  endtask

  task automatic model_edge(input bit rd, input bit rq);
    bit raw[2];
    int pre;
    bit e_d, e_q, pop, t, flip, nar, samp1;
    raw[0] = rq;
    raw[1] = rd;
    pre = fq.size();
    e_d = rise[1];
    e_q = rise[0];
    pop = (cool == 0) && (pre > 0);
    ex_D = 0; ex_Q = 0; ex_drop = 0;
    ex_rej = e_d & e_q;
    if (pop) begin
      t = fq.pop_front();
      ex_D = t;
      ex_Q = !t;
      cool = GAP + 1;
    end else if (cool > 0) begin
      cool--;
    end
    if (e_d ^ e_q) begin
      if (pre < DEPTH || pop) fq.push_back(e_d);
      else ex_drop = 1;
    end
    ex_full = (fq.size() == DEPTH);
    if (ex_D && ex_dcnt < 255) ex_dcnt++;
    if (ex_Q && ex_qcnt < 255) ex_qcnt++;
    for (int i = 0; i < 2; i++) begin
      samp1 = (h2[i] == 1);
      nar = arm[i] || (h2[i] == 0 && !lvl[i]);
      flip = 0;
      if (samp1 != lvl[i]) begin
        run[i]++;
        if (run[i] == DB) begin
          lvl[i] = !lvl[i];
          run[i] = 0;
          flip = 1;
        end
      end else begin
        run[i] = 0;
      end
      rise[i] = flip && lvl[i] && nar;
      arm[i] = nar;
      h2[i] = h1[i];
      h1[i] = raw[i];
    end
  endtask

  task automatic check_outs();
    chk("D_in", D_in, ex_D);
    chk("Q_in", Q_in, ex_Q);
    chk("coin_reject", coin_reject, ex_rej);
    chk("coin_drop", coin_drop, ex_drop);
    chk("fifo_full", fifo_full, ex_full);
`ifdef COIN_ACCEPTOR_STATS_EN
    chk("dollar_count", dollar_count, ex_dcnt[7:0]);
    chk("quarter_count", quarter_count, ex_qcnt[7:0]);
`endif
  endtask

  // Called at a falling edge; drives inputs, steps model on the rising edge.
  task automatic tick(input bit d, input bit q);
    coin_dollar_raw = d;
    coin_quarter_raw = q;
    @(posedge clock);
    model_edge(d, q);
    @(negedge clock);
    tickno++;
    check_outs();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_D_in"}, D_in, 0);
    chk({tag, "_Q_in"}, Q_in, 0);
    chk({tag, "_reject"}, coin_reject, 0);
    chk({tag, "_drop"}, coin_drop, 0);
    chk({tag, "_full"}, fifo_full, 0);
  endtask

  int lat, npulse, nrej, ndrop, sawfull, last, mingap, waitn;
  bit rd, rq;
  int hd, hq;

  initial begin
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick(0, 0);

    // Single dollar and its latency.
    lat = 0;
    npulse = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1, 0);
      if (D_in && lat == 0) lat = i;
      npulse += int'(D_in) + int'(Q_in);
    end
    for (int i = 0; i < 20; i++) begin
      tick(0, 0);
      npulse += int'(D_in) + int'(Q_in);
    end
    chk("dollar_latency", 16'(lat), 8);
    chk("dollar_pulses", 16'(npulse), 1);

    // Bouncy quarter, then an isolated 3-cycle glitch.
    npulse = 0;
    tick(0, 1); tick(0, 0); tick(0, 1); tick(0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 1);
      npulse += int'(Q_in);
    end
    for (int i = 0; i < 20; i++) begin
      tick(0, 0);
      npulse += int'(Q_in);
    end
    chk("bounce_pulses", 16'(npulse), 1);
    npulse = 0;
    for (int i = 0; i < 3; i++) tick(0, 1);
    for (int i = 0; i < 20; i++) begin
      tick(0, 0);
      npulse += int'(Q_in) + int'(D_in);
    end
    chk("glitch_pulses", 16'(npulse), 0);

    // Both lines together.
    npulse = 0;
    nrej = 0;
    for (int i = 0; i < 30; i++) begin
      tick(i < 10, i < 10);
      npulse += int'(Q_in) + int'(D_in);
      nrej += int'(coin_reject);
    end
    chk("simul_reject", 16'(nrej), 1);
    chk("simul_pulses", 16'(npulse), 0);

    // Interleaved lines outpace the issue rate to fill the FIFO.
    ndrop = 0;
    sawfull = 0;
    last = -1;
    mingap = 1000;
    for (int i = 0; i < 200; i++) begin
      tick((i % 8) < 4, (i % 8) >= 4);
      ndrop += int'(coin_drop);
      if (fifo_full) sawfull = 1;
      if (D_in || Q_in) begin
        if (last >= 0 && tickno - last < mingap) mingap = tickno - last;
        last = tickno;
      end
    end
    chk("backlog_full_seen", 16'(sawfull), 1);
    chk("backlog_drops_seen", 16'(ndrop > 0), 1);
    chk("issue_spacing", 16'(mingap), 16'(GAP + 2));

    // Reset with >=3 queued and issue FSM in its gap.
    waitn = 0;
    while (!(fq.size() >= 3 && cool >= 1 && cool <= GAP) && waitn < 100) begin
      tick((waitn % 8) < 4, (waitn % 8) >= 4);
      waitn++;
    end
    chk("midreset_reached", 16'(waitn < 100), 1);
    rst_n = 1'b0;
    coin_dollar_raw = 1'b1;
    coin_quarter_raw = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    @(negedge clock);
    rst_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1, 0);
      npulse += int'(D_in) + int'(Q_in);
    end
    chk("held_through_reset", 16'(npulse), 0);
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      tick(i >= 10 && i < 20, 0);
      npulse += int'(D_in);
    end
    chk("rearmed_dollar", 16'(npulse), 1);

    // Randomized independent bouncy lines.
    rd = 0; rq = 0; hd = 0; hq = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hd == 0) begin
        rd = !rd;
        hd = $urandom_range(1, 10);
      end
      if (hq == 0) begin
        rq = !rq;
        hq = $urandom_range(1, 10);
      end
      tick(rd, rq);
      hd--;
      hq--;
    end
    for (int i = 0; i < 40; i++) tick(0, 0);

`ifdef COIN_ACCEPTOR_STATS_EN
    for (int i = 0; i < 3000; i++) tick((i % 10) < 5, 0);
    for (int i = 0; i < 20; i++) tick(0, 0);
    chk("dollar_saturated", 16'(dollar_count), 255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
